// File: rtl/fft_mem_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIT FFT on a dual-port SRAM.
// Read addresses are registered; a BFLY_LAT-deep delay line turns them into write addresses.
module fft_mem_sequencer #(
  parameter int BFLY_LAT = 2,
  parameter int ADDR_W   = 9,
  parameter int TW_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        log2n,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [TW_W-1:0]   tw_addr,
  output logic [3:0]        stage,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] wr_addr2
);

  localparam int BW = ADDR_W - 1;
  localparam int XW = ADDR_W + 1;
  localparam logic [2:0] LAT_M1 = 3'(BFLY_LAT - 1);

  typedef enum logic [2:0] {IDLE, READ, BUBBLE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      l_q, l_d;
  logic [3:0]      s_q, s_d;
  logic [BW-1:0]   b_q, b_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            cfgErr_d;
  logic [BW-1:0]   lastB;

  logic              busy_q, done_q, cfgErr_q, rdEn_q;
  logic [ADDR_W-1:0] rdAddr1_q, rdAddr2_q;
  logic [TW_W-1:0]   twAddr_q;
  logic [3:0]        stage_q;

  assign lastB = BW'((XW'(1) << (l_q - 4'd1)) - XW'(1));

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    s_d      = s_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    cfgErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (log2n >= 4'd3 && log2n <= 4'd9) begin
            l_d     = log2n;
            s_d     = 4'd0;
            b_d     = '0;
            state_d = READ;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      READ: begin
        if (b_q == lastB) begin
          cnt_d   = 3'd0;
          state_d = (s_q == l_q - 4'd1) ? DRAIN : BUBBLE;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      BUBBLE: begin
        if (cnt_q == LAT_M1) begin
          s_d     = s_q + 4'd1;
          b_d     = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAT_M1) state_d = DONE;
        else                 cnt_d   = cnt_q + 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are derived from the next butterfly so they can be registered alongside rd_en.
  logic [XW-1:0] h, bExt, j, g, a1, a2, twFull;
  assign h      = XW'(1) << s_d;
  assign bExt   = XW'(b_d);
  assign j      = bExt & (h - XW'(1));
  assign g      = bExt >> s_d;
  assign a1     = (g << (s_d + 4'd1)) | j;
  assign a2     = a1 + h;
  assign twFull = j << (4'(TW_W) - s_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      l_q       <= '0;
      s_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfgErr_q  <= 1'b0;
      rdEn_q    <= 1'b0;
      rdAddr1_q <= '0;
      rdAddr2_q <= '0;
      twAddr_q  <= '0;
      stage_q   <= '0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      s_q      <= s_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == READ) || (state_d == BUBBLE) || (state_d == DRAIN);
      done_q   <= (state_d == DONE);
      cfgErr_q <= cfgErr_d;
      rdEn_q   <= (state_d == READ);
      if (state_d == READ) begin
        rdAddr1_q <= a1[ADDR_W-1:0];
        rdAddr2_q <= a2[ADDR_W-1:0];
        twAddr_q  <= twFull[TW_W-1:0];
        stage_q   <= s_d;
      end
    end
  end

  // Write-side delay line matching the butterfly pipeline depth.
  logic              wrEnPipe_q [BFLY_LAT];
  logic [ADDR_W-1:0] wrA1Pipe_q [BFLY_LAT];
  logic [ADDR_W-1:0] wrA2Pipe_q [BFLY_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        wrEnPipe_q[i] <= 1'b0;
        wrA1Pipe_q[i] <= '0;
        wrA2Pipe_q[i] <= '0;
      end
    end else begin
      wrEnPipe_q[0] <= rdEn_q;
      wrA1Pipe_q[0] <= rdAddr1_q;
      wrA2Pipe_q[0] <= rdAddr2_q;
      for (int i = 1; i < BFLY_LAT; i++) begin
        wrEnPipe_q[i] <= wrEnPipe_q[i-1];
        wrA1Pipe_q[i] <= wrA1Pipe_q[i-1];
        wrA2Pipe_q[i] <= wrA2Pipe_q[i-1];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfgErr_q;
  assign rd_en    = rdEn_q;
  assign rd_addr1 = rdAddr1_q;
  assign rd_addr2 = rdAddr2_q;
  assign tw_addr  = twAddr_q;
  assign stage    = stage_q;
  assign wr_en    = wrEnPipe_q[BFLY_LAT-1];
  assign wr_addr1 = wrA1Pipe_q[BFLY_LAT-1];
  assign wr_addr2 = wrA2Pipe_q[BFLY_LAT-1];

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed bench for fft_mem_sequencer: cycle table for an 8-point frame plus
// restart-ignore, mid-frame reset, illegal-size and 512-point corner sequences.
module tb_fft_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] log2n = 4'd0;
  logic       busy, done, cfg_err, rd_en, wr_en;
  logic [8:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic [7:0] tw_addr;
  logic [3:0] stage;

  int compared = 0;
  int mismatched = 0;

  fft_mem_sequencer #(.BFLY_LAT(2), .ADDR_W(9), .TW_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .tw_addr(tw_addr), .stage(stage),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd, a1, a2, tw, stg, wr, wa1, wa2, bsy, dn;
  } vec_t;

  vec_t vec [21];

  function automatic logic [52:0] packExp(input vec_t v);
    return {1'b0, 1'(v.bsy), 1'(v.dn), 1'(v.rd), 9'(v.a1), 9'(v.a2), 8'(v.tw),
            4'(v.stg), 1'(v.wr), 9'(v.wa1), 9'(v.wa2)};
  endfunction

  function automatic logic [52:0] packAct();
    return {cfg_err, busy, done, rd_en, rd_addr1, rd_addr2, tw_addr, stage,
            wr_en, wr_addr1, wr_addr2};
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [52:0] act, input logic [52:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the 8-point frame against the table; optional re-start and mid-frame reset.
  task automatic applyStimulus(input int restartAt, input int abortAt);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      start = (i == 0) || (i == restartAt);
      log2n = (i == 0) ? 4'd3 : 4'd5;
      checkOutput("seq", i, packAct(), packExp(vec[i]));
      if (i == abortAt) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("abort", i, packAct(), 53'd0);
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkCfgErr(input logic [3:0] badN);
    @(negedge clk);
    start = 1'b1;
    log2n = badN;
    @(negedge clk);
    start = 1'b0;
    checkValue("cfgErrPulse", {29'd0, cfg_err, busy, rd_en}, 3'b100);
    @(negedge clk);
    checkValue("cfgErrClear", {29'd0, cfg_err, busy, rd_en}, 3'b000);
  endtask

  task automatic runFull512();
    int busyCnt = 0, wrCnt = 0, clash = 0, cyc = 0;
    int rdCnt [16];
    int s8a1 = -1, s8a2 = -1, s8tw = -1, last0a1 = -1, last0a2 = -1;
    for (int k = 0; k < 16; k++) rdCnt[k] = 0;
    @(negedge clk);
    start = 1'b1;
    log2n = 4'd9;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 3000) begin
      if (busy) busyCnt++;
      if (rd_en) begin
        rdCnt[stage]++;
        if (stage == 4'd8 && s8a1 < 0) begin
          s8a1 = rd_addr1; s8a2 = rd_addr2; s8tw = tw_addr;
        end
        if (stage == 4'd0) begin
          last0a1 = rd_addr1; last0a2 = rd_addr2;
        end
      end
      if (wr_en) begin
        wrCnt++;
        if (wr_addr1 == wr_addr2) clash++;
      end
      @(negedge clk);
      cyc++;
    end
    checkValue("done512", int'(done), 1);
    checkValue("busy512", busyCnt, 2322);
    for (int k = 0; k < 9; k++) checkValue($sformatf("rdStage%0d", k), rdCnt[k], 256);
    checkValue("s8a1", s8a1, 0);
    checkValue("s8a2", s8a2, 256);
    checkValue("s8tw", s8tw, 0);
    checkValue("last0a1", last0a1, 510);
    checkValue("last0a2", last0a2, 511);
    checkValue("wr512", wrCnt, 2304);
    checkValue("wrClash", clash, 0);
  endtask

  initial begin
    //            rd a1 a2  tw stg wr wa1 wa2 bsy dn
    vec[0]  = '{0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 1,   0, 0, 0, 0, 0, 1, 0};
    vec[2]  = '{1, 2, 3,   0, 0, 0, 0, 0, 1, 0};
    vec[3]  = '{1, 4, 5,   0, 0, 1, 0, 1, 1, 0};
    vec[4]  = '{1, 6, 7,   0, 0, 1, 2, 3, 1, 0};
    vec[5]  = '{0, 6, 7,   0, 0, 1, 4, 5, 1, 0};
    vec[6]  = '{0, 6, 7,   0, 0, 1, 6, 7, 1, 0};
    vec[7]  = '{1, 0, 2,   0, 1, 0, 6, 7, 1, 0};
    vec[8]  = '{1, 1, 3, 128, 1, 0, 6, 7, 1, 0};
    vec[9]  = '{1, 4, 6,   0, 1, 1, 0, 2, 1, 0};
    vec[10] = '{1, 5, 7, 128, 1, 1, 1, 3, 1, 0};
    vec[11] = '{0, 5, 7, 128, 1, 1, 4, 6, 1, 0};
    vec[12] = '{0, 5, 7, 128, 1, 1, 5, 7, 1, 0};
    vec[13] = '{1, 0, 4,   0, 2, 0, 5, 7, 1, 0};
    vec[14] = '{1, 1, 5,  64, 2, 0, 5, 7, 1, 0};
    vec[15] = '{1, 2, 6, 128, 2, 1, 0, 4, 1, 0};
    vec[16] = '{1, 3, 7, 192, 2, 1, 1, 5, 1, 0};
    vec[17] = '{0, 3, 7, 192, 2, 1, 2, 6, 1, 0};
    vec[18] = '{0, 3, 7, 192, 2, 1, 3, 7, 1, 0};
    vec[19] = '{0, 3, 7, 192, 2, 0, 3, 7, 0, 1};
    vec[20] = '{0, 3, 7, 192, 2, 0, 3, 7, 0, 0};

    applyReset();
    applyStimulus(-1, -1);
    applyReset();
    applyStimulus(5, -1);
    applyReset();
    applyStimulus(-1, 8);
    applyReset();
    applyStimulus(-1, -1);

    applyReset();
    checkCfgErr(4'd2);
    checkCfgErr(4'd10);

    applyReset();
    runFull512();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_mem_sequencer.md
Name: fft_mem_sequencer

Overview:
Stage/butterfly sequencer for the in-place radix-2 DIT FFT built around the dual-port 512-word ping-less SRAM (2 reads/2 writes per cycle; reads combinational, writes committed at the clock edge).
- Generates per-cycle read address pairs, twiddle index and read enable.
- Generates write address pairs and write enable, delayed to match the butterfly pipeline.
- Inserts stage-boundary bubbles so no stage reads data still in flight.
- Supports N = 8..512 points selected per frame.

Parameters:
BFLY_LAT, 2, butterfly pipeline depth in cycles from read-data sample to result presented on SRAM write inputs (legal 1..7)
ADDR_W, 9, SRAM address width (fixed 9 for 512 words)
TW_W, 8, twiddle ROM index width (256-entry W_512^k table)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request
log2n  in  4  log2 of FFT size, legal 3..9, sampled on accepted start
busy  out  1  high from accepted start until last write cycle inclusive
done  out  1  one-cycle pulse, cycle after last write
cfg_err  out  1  one-cycle pulse when start rejected for illegal log2n
rd_en  out  1  read cycle valid
rd_addr1  out  9  butterfly upper-input address
rd_addr2  out  9  butterfly lower-input address
tw_addr  out  8  twiddle index, aligned with rd_addr*
stage  out  4  current read stage index
wr_en  out  1  write cycle valid
wr_addr1  out  9  upper-output address
wr_addr2  out  9  lower-output address

Behaviour:
- Clock/reset: single clock `clk`. Reset is asynchronous, active-low, on `rst_n`. Reset forces all outputs and state to 0, FSM to IDLE and clears the delay line. Reset mid-frame aborts immediately; no further wr_en.
- FSM states: IDLE, READ, BUBBLE, DRAIN, DONE.
  - IDLE: start with log2n in 3..9 latches L=log2n, clears s=0 and b=0, goes to READ (first read cycle is the next cycle).
  - IDLE: start with an illegal log2n pulses cfg_err the next cycle and stays IDLE.
  - start outside IDLE is ignored.
  - READ: rd_en=1, one butterfly per cycle, b=0..2^(L-1)-1.
  - READ at the last b with s<L-1: go to BUBBLE. READ at the last b with s=L-1: go to DRAIN.
  - BUBBLE: exactly BFLY_LAT cycles with rd_en=0, then s+=1, b=0, back to READ. This guarantees the first read of stage s+1 occurs the cycle after the last write of stage s.
  - DRAIN: BFLY_LAT cycles with rd_en=0 while the final writes complete, then DONE.
  - DONE: done=1, busy=0 for one cycle, then IDLE.
- Address generation, with h=2^s, j=b mod h, g=b>>s:
  - rd_addr1 = (g<<(s+1)) | j
  - rd_addr2 = rd_addr1 + h
  - tw_addr = j<<(8-s), independent of N
  - Upper address bits above L are always 0.
- Outputs rd_addr*, tw_addr and stage are registered and valid in the same cycle as rd_en. When rd_en=0 they hold their last value.
- Write path: {rd_en, rd_addr1, rd_addr2} pass through a BFLY_LAT-stage shift register to {wr_en, wr_addr1, wr_addr2}.
  - The shift register is cleared on reset only.
  - wr_en is high exactly BFLY_LAT cycles after each rd_en cycle.
- busy is high from the first READ cycle through the last wr_en cycle.
- Total busy cycles = L*(2^(L-1)+BFLY_LAT).
- wr_addr1 never equals wr_addr2. Within a stage, no address is read twice.

Test Plan:
- log2n=3, BFLY_LAT=2, start at cycle 0 -> expected read sequence:
  - stage0 reads cycles 1-4, pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - stage1 reads cycles 7-10, pairs (0,2)(1,3)(4,6)(5,7), tw 0,128,0,128.
  - stage2 reads cycles 13-16, pairs (0,4)(1,5)(2,6)(3,7), tw 0,64,128,192.
- Same run -> write timing:
  - wr_en on cycles 3-6, 9-12 and 15-18 with wr_addr matching the reads 2 cycles earlier.
  - busy cycles 1-18 (18 cycles); done pulse at cycle 19.
- log2n=9 -> 2322 busy cycles; 256 rd_en cycles per stage; stage8 pair 0 = (0,256), tw 0; stage0 last pair = (510,511).
- start with log2n=2, then log2n=10 -> cfg_err pulse each time, busy stays 0, no rd_en.
- start asserted again during busy (e.g. at cycle 5) -> ignored; sequence identical to the first scenario.
- rst_n low at cycle 8 of the log2n=3 run -> all outputs 0 immediately; after release, a new start produces the clean first-scenario sequence with no stale wr_en.
